id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between the decode/control stage and the execute stage of the RV32I core.
- Captures the control word produced by the opcode decoder, plus operands and register indices, on each clock.
- Detects load-use hazards, stalls upstream, and inserts a bubble.
- Also supports squashing the captured instruction on a taken branch/jump and keeps a saturating count of hazard bubbles.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate)
- CNT_W, 16, width of the bubble counter

Ports:
- iCLK  in  1  core clock, all state on rising edge
- iRST  in  1  asynchronous reset, active-low
- iValid  in  1  decode stage holds a real instruction
- iHold  in  1  global freeze (memory wait); register holds all state
- iFlush  in  1  taken branch/jump resolved in EX; squash the instruction entering EX
- iOrigALU  in  1  control word field from decoder
- iMem2Reg  in  2  control word field from decoder
- iRegWrite  in  1  control word field from decoder
- iMemRead  in  1  control word field from decoder
- iMemWrite  in  1  control word field from decoder
- iALUOp  in  2  control word field from decoder
- iOrigPC  in  2  control word field from decoder
- iOPBJ  in  1  control word field from decoder
- iCStore  in  2  control word field from decoder
- iPC  in  XLEN  PC of the decoding instruction
- iRead1  in  XLEN  rs1 data
- iRead2  in  XLEN  rs2 data
- iImm  in  XLEN  immediate
- iRs1  in  5  source register index
- iRs2  in  5  source register index
- iRd  in  5  destination register index
- iFunct3  in  3  funct3
- iFunct7b5  in  1  instruction bit 30
- oValid, oOrigALU, oMem2Reg, oRegWrite, oMemRead, oMemWrite, oALUOp, oOrigPC, oOPBJ, oCStore  out  as inputs  registered control word
- oPC, oRead1, oRead2, oImm, oRs1, oRs2, oRd, oFunct3, oFunct7b5  out  as inputs  registered data
- oStall  out  1  combinational; freeze PC and IF/ID
- oBubbleCnt  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset (iRST=0, asynchronous): all outputs and registers go to 0. The zero control word is a NOP: no write, no memory access, oOrigPC=00.

Hazard detection (combinational on current state):
- oStall = iValid & oValid & oMemRead & (oRd!=0) & ((oRd==iRs1)|(oRd==iRs2)) & ~iFlush.
- Comparison ignores whether the instruction actually uses rs2. A false stall is acceptable; a missed stall is not.

Per rising edge, in priority order:
1. iFlush=1: bubble. oValid=0, oRegWrite=0, oMemRead=0, oMemWrite=0, oCStore=00, oOrigPC=00, oOPBJ=0; all other outputs=0. Flush overrides iHold. oBubbleCnt is unchanged.
2. iHold=1: all registers keep their values; oBubbleCnt unchanged.
3. oStall=1: same bubble as flush. oBubbleCnt increments by 1 and saturates at 2^CNT_W-1.
4. Otherwise: load all inputs. If iValid=0, load a bubble instead of the inputs.

Timing and boundary cases:
- Latency is 1 cycle, input to output.
- A load followed by a dependent instruction produces exactly one bubble. On the next cycle oMemRead of the bubble is 0, so oStall drops and the dependent instruction loads.
- iHold with a pending hazard: oStall stays 1 and no bubble is counted until iHold falls.
- Reset mid-stall clears state and drops oStall immediately (combinational path via oValid=0).
- rd=x0 never stalls.

Test Plan:
1. Reset then release, no stimulus -> all outputs 0 and oStall=0; a LOAD control word with iValid=1 appears on outputs 1 cycle later with oMemRead=1, oMem2Reg=01.
2. LW x5 captured, next decode iRs1=5 -> oStall=1 for exactly 1 cycle; EX shows bubble (oValid=0, oRegWrite=0); oBubbleCnt 0->1; the dependent instruction is captured the following cycle.
3. LW x0 followed by iRs1=0 -> oStall=0, no bubble, counter unchanged.
4. iFlush=1 together with a hazard and iHold=1 -> next cycle a bubble is loaded, oStall=0 during flush, counter unchanged.
5. iHold=1 for 3 cycles with a STORE in EX -> oMemWrite=1, oCStore=10 held constant; no counter change.
6. Preload counter near max (CNT_W=4) with 16 load-use hazards -> oBubbleCnt saturates at 15; assert iRST low mid-stall -> counter and oStall reach 0 asynchronously.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures the decoded control word and operands,
// stalls decode on a load-use hazard and injects a bubble, squashes on taken branch/jump.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    input  logic            iHold,
    input  logic            iFlush,
    input  logic            iOrigALU,
    input  logic [1:0]      iMem2Reg,
    input  logic            iRegWrite,
    input  logic            iMemRead,
    input  logic            iMemWrite,
    input  logic [1:0]      iALUOp,
    input  logic [1:0]      iOrigPC,
    input  logic            iOPBJ,
    input  logic [1:0]      iCStore,
    input  logic [XLEN-1:0] iPC,
    input  logic [XLEN-1:0] iRead1,
    input  logic [XLEN-1:0] iRead2,
    input  logic [XLEN-1:0] iImm,
    input  logic [4:0]      iRs1,
    input  logic [4:0]      iRs2,
    input  logic [4:0]      iRd,
    input  logic [2:0]      iFunct3,
    input  logic            iFunct7b5,
    output logic            oValid,
    output logic            oOrigALU,
    output logic [1:0]      oMem2Reg,
    output logic            oRegWrite,
    output logic            oMemRead,
    output logic            oMemWrite,
    output logic [1:0]      oALUOp,
    output logic [1:0]      oOrigPC,
    output logic            oOPBJ,
    output logic [1:0]      oCStore,
    output logic [XLEN-1:0] oPC,
    output logic [XLEN-1:0] oRead1,
    output logic [XLEN-1:0] oRead2,
    output logic [XLEN-1:0] oImm,
    output logic [4:0]      oRs1,
    output logic [4:0]      oRs2,
    output logic [4:0]      oRd,
    output logic [2:0]      oFunct3,
    output logic            oFunct7b5,
    output logic            oStall,
    output logic [CNT_W-1:0] oBubbleCnt
);

    logic loadUseHit;
    logic loadBubble;
    logic loadInput;
    logic countBubble;

    // rs2 is compared even for instructions that do not read it; a spurious stall is harmless.
    assign loadUseHit = oValid & oMemRead & (oRd != 5'd0) & ((oRd == iRs1) | (oRd == iRs2));
    assign oStall     = iValid & loadUseHit & ~iFlush;

    assign loadBubble  = iFlush | (~iHold & (oStall | ~iValid));
    assign loadInput   = ~iFlush & ~iHold & ~oStall & iValid;
    assign countBubble = ~iFlush & ~iHold & oStall;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oValid    <= 1'b0;
            oOrigALU  <= 1'b0;
            oMem2Reg  <= 2'b00;
            oRegWrite <= 1'b0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oALUOp    <= 2'b00;
            oOrigPC   <= 2'b00;
            oOPBJ     <= 1'b0;
            oCStore   <= 2'b00;
            oPC       <= '0;
            oRead1    <= '0;
            oRead2    <= '0;
            oImm      <= '0;
            oRs1      <= 5'd0;
            oRs2      <= 5'd0;
            oRd       <= 5'd0;
            oFunct3   <= 3'd0;
            oFunct7b5 <= 1'b0;
        end else if (loadBubble) begin
            // The all-zero word is a NOP: no register write, no memory access, sequential PC.
            oValid    <= 1'b0;
            oOrigALU  <= 1'b0;
            oMem2Reg  <= 2'b00;
            oRegWrite <= 1'b0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oALUOp    <= 2'b00;
            oOrigPC   <= 2'b00;
            oOPBJ     <= 1'b0;
            oCStore   <= 2'b00;
            oPC       <= '0;
            oRead1    <= '0;
            oRead2    <= '0;
            oImm      <= '0;
            oRs1      <= 5'd0;
            oRs2      <= 5'd0;
            oRd       <= 5'd0;
            oFunct3   <= 3'd0;
            oFunct7b5 <= 1'b0;
        end else if (loadInput) begin
            oValid    <= 1'b1;
            oOrigALU  <= iOrigALU;
            oMem2Reg  <= iMem2Reg;
            oRegWrite <= iRegWrite;
            oMemRead  <= iMemRead;
            oMemWrite <= iMemWrite;
            oALUOp    <= iALUOp;
            oOrigPC   <= iOrigPC;
            oOPBJ     <= iOPBJ;
            oCStore   <= iCStore;
            oPC       <= iPC;
            oRead1    <= iRead1;
            oRead2    <= iRead2;
            oImm      <= iImm;
            oRs1      <= iRs1;
            oRs2      <= iRs2;
            oRd       <= iRd;
            oFunct3   <= iFunct3;
            oFunct7b5 <= iFunct7b5;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oBubbleCnt <= '0;
        end else if (countBubble && (oBubbleCnt != {CNT_W{1'b1}})) begin
            oBubbleCnt <= oBubbleCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a transaction-level model of the EX slot.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic            valid;
        logic            origAlu;
        logic [1:0]      mem2Reg;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic [1:0]      aluOp;
        logic [1:0]      origPc;
        logic            opbj;
        logic [1:0]      cStore;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] read1;
        logic [XLEN-1:0] read2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
    } bundle_t;

    logic clk = 1'b0;
    logic rstN;
    logic hold;
    logic flush;
    bundle_t inB;
    bundle_t dutB;

    logic            oValid, oOrigALU, oRegWrite, oMemRead, oMemWrite, oOPBJ, oFunct7b5, oStall;
    logic [1:0]      oMem2Reg, oALUOp, oOrigPC, oCStore;
    logic [XLEN-1:0] oPC, oRead1, oRead2, oImm;
    logic [4:0]      oRs1, oRs2, oRd;
    logic [2:0]      oFunct3;
    logic [CNT_W-1:0] oBubbleCnt;

    bundle_t modEx;
    int      modCnt;
    int      checks = 0;
    int      failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .iCLK(clk), .iRST(rstN), .iValid(inB.valid), .iHold(hold), .iFlush(flush),
        .iOrigALU(inB.origAlu), .iMem2Reg(inB.mem2Reg), .iRegWrite(inB.regWrite),
        .iMemRead(inB.memRead), .iMemWrite(inB.memWrite), .iALUOp(inB.aluOp),
        .iOrigPC(inB.origPc), .iOPBJ(inB.opbj), .iCStore(inB.cStore),
        .iPC(inB.pc), .iRead1(inB.read1), .iRead2(inB.read2), .iImm(inB.imm),
        .iRs1(inB.rs1), .iRs2(inB.rs2), .iRd(inB.rd), .iFunct3(inB.funct3),
        .iFunct7b5(inB.funct7b5),
        .oValid(oValid), .oOrigALU(oOrigALU), .oMem2Reg(oMem2Reg), .oRegWrite(oRegWrite),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oALUOp(oALUOp), .oOrigPC(oOrigPC),
        .oOPBJ(oOPBJ), .oCStore(oCStore), .oPC(oPC), .oRead1(oRead1), .oRead2(oRead2),
        .oImm(oImm), .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd), .oFunct3(oFunct3),
        .oFunct7b5(oFunct7b5), .oStall(oStall), .oBubbleCnt(oBubbleCnt)
    );

    assign dutB = {oValid, oOrigALU, oMem2Reg, oRegWrite, oMemRead, oMemWrite, oALUOp, oOrigPC,
                   oOPBJ, oCStore, oPC, oRead1, oRead2, oImm, oRs1, oRs2, oRd, oFunct3, oFunct7b5};

    // Reference: a load in EX whose rd (non-zero) names a source of the decoding instruction.
    function automatic bit modelStall();
        return inB.valid && modEx.valid && modEx.memRead && (modEx.rd != 0)
               && (modEx.rd == inB.rs1 || modEx.rd == inB.rs2) && !flush;
    endfunction

    function automatic bundle_t randInstr();
        bundle_t b;
        b = bundle_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        b.valid = 1'b1;
        return b;
    endfunction

    function automatic bundle_t makeLoad(input logic [4:0] rd, input logic [4:0] rs1);
        bundle_t b;
        b = randInstr();
        b.memRead = 1'b1; b.mem2Reg = 2'b01; b.regWrite = 1'b1; b.memWrite = 1'b0;
        b.rd = rd; b.rs1 = rs1;
        return b;
    endfunction

    function automatic bundle_t makeAlu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bundle_t b;
        b = randInstr();
        b.memRead = 1'b0; b.memWrite = 1'b0; b.regWrite = 1'b1; b.mem2Reg = 2'b00;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        return b;
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic cycle();
        bit st;
        st = modelStall();
        if (flush) begin
            modEx = '0;
        end else if (hold) begin
            modEx = modEx;
        end else if (st) begin
            modEx = '0;
            modCnt = (modCnt + 1 > int'(CNT_MAX)) ? int'(CNT_MAX) : modCnt + 1;
        end else begin
            modEx = inB.valid ? inB : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        #2;
        rstN = 1'b0;
        modEx = '0;
        modCnt = 0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; hold = 0; flush = 0; inB = '0;
        modEx = '0; modCnt = 0;
        #3;
        checks++;
        if (dutB !== '0 || oBubbleCnt !== '0 || oStall !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%h cnt=%0d stall=%b want=0", dutB, oBubbleCnt, oStall);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        cycle();
        cycle();
        checks++;
        if (dutB !== '0 || oStall !== 1'b0 || oBubbleCnt !== '0) begin
            failures++;
            $display("FAIL reset_idle got=%h stall=%b cnt=%0d want=0", dutB, oStall, oBubbleCnt);
        end
    endtask

    task automatic test_load_visible();
        inB = makeLoad(5'd7, 5'd1);
        inB.rs2 = 5'd2;
        cycle();
        inB = '0;
        checks++;
        if (oMemRead !== 1'b1 || oMem2Reg !== 2'b01 || oValid !== 1'b1) begin
            failures++;
            $display("FAIL load_ctrl got memRead=%b mem2Reg=%b valid=%b want 1 01 1",
                     oMemRead, oMem2Reg, oValid);
        end
        checks++;
        if (dutB !== modEx) begin
            failures++;
            $display("FAIL load_word got=%h want=%h", dutB, modEx);
        end
    endtask

    task automatic test_load_use();
        bundle_t dep;
        int cnt0;
        cnt0 = modCnt;
        inB = makeLoad(5'd5, 5'd3);
        inB.rs2 = 5'd4;
        cycle();
        dep = makeAlu(5'd9, 5'd5, 5'd6);
        inB = dep;
        #1;
        checks++;
        if (oStall !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_stall got=%b want=1", oStall);
        end
        cycle();
        checks++;
        if (oValid !== 1'b0 || oRegWrite !== 1'b0 || dutB !== '0) begin
            failures++;
            $display("FAIL loaduse_bubble got=%h want=0", dutB);
        end
        checks++;
        if (oBubbleCnt !== CNT_W'(cnt0 + 1) || oStall !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_cnt got cnt=%0d stall=%b want cnt=%0d stall=0",
                     oBubbleCnt, oStall, cnt0 + 1);
        end
        cycle();
        inB = '0;
        checks++;
        if (dutB !== dep) begin
            failures++;
            $display("FAIL loaduse_dep got=%h want=%h", dutB, dep);
        end
    endtask

    task automatic test_x0();
        bundle_t dep;
        int cnt0;
        cnt0 = modCnt;
        inB = makeLoad(5'd0, 5'd3);
        cycle();
        dep = makeAlu(5'd8, 5'd0, 5'd0);
        inB = dep;
        #1;
        checks++;
        if (oStall !== 1'b0) begin
            failures++;
            $display("FAIL x0_stall got=%b want=0", oStall);
        end
        cycle();
        inB = '0;
        checks++;
        if (dutB !== dep || oBubbleCnt !== CNT_W'(cnt0)) begin
            failures++;
            $display("FAIL x0_capture got=%h cnt=%0d want=%h cnt=%0d", dutB, oBubbleCnt, dep, cnt0);
        end
    endtask

    task automatic test_flush();
        int cnt0;
        cnt0 = modCnt;
        inB = makeLoad(5'd12, 5'd1);
        cycle();
        inB = makeAlu(5'd13, 5'd12, 5'd12);
        hold = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (oStall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b want=0", oStall);
        end
        cycle();
        hold = 1'b0;
        flush = 1'b0;
        inB = '0;
        checks++;
        if (dutB !== '0 || oBubbleCnt !== CNT_W'(cnt0)) begin
            failures++;
            $display("FAIL flush_bubble got=%h cnt=%0d want=0 cnt=%0d", dutB, oBubbleCnt, cnt0);
        end
    endtask

    task automatic test_hold();
        bundle_t st;
        int cnt0;
        cnt0 = modCnt;
        st = randInstr();
        st.memWrite = 1'b1; st.memRead = 1'b0; st.regWrite = 1'b0; st.cStore = 2'b10;
        inB = st;
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inB = randInstr();
            cycle();
            checks++;
            if (dutB !== st || oMemWrite !== 1'b1 || oCStore !== 2'b10 || oBubbleCnt !== CNT_W'(cnt0)) begin
                failures++;
                $display("FAIL hold_%0d got=%h cnt=%0d want=%h cnt=%0d", i, dutB, oBubbleCnt, st, cnt0);
            end
        end
        hold = 1'b0;
        inB = '0;
        cycle();
    endtask

    task automatic test_back_to_back();
        int errs;
        logic [4:0] lastRd;
        errs = 0;
        lastRd = 5'd1;
        for (int i = 0; i < 300; i++) begin
            inB = randInstr();
            inB.valid = ($urandom_range(0, 7) != 0);
            inB.memRead = ($urandom_range(0, 2) == 0);
            inB.rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) inB.rs1 = lastRd;
            else inB.rs1 = 5'($urandom_range(0, 7));
            inB.rs2 = 5'($urandom_range(0, 7));
            hold = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            lastRd = inB.rd;
            #1;
            checks++;
            if (oStall !== logic'(modelStall())) begin
                failures++;
                if (errs++ < 10) $display("FAIL rand_stall[%0d] got=%b want=%b", i, oStall, modelStall());
            end
            cycle();
            checks++;
            if (dutB !== modEx || oBubbleCnt !== CNT_W'(modCnt)) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL rand_state[%0d] got=%h cnt=%0d want=%h cnt=%0d",
                             i, dutB, oBubbleCnt, modEx, modCnt);
            end
        end
        hold = 0;
        flush = 0;
        inB = '0;
    endtask

    task automatic test_saturate_reset();
        applyReset();
        inB = makeLoad(5'd5, 5'd5);
        for (int i = 0; i < 34; i++) cycle();
        checks++;
        if (oBubbleCnt !== CNT_MAX || modCnt != int'(CNT_MAX)) begin
            failures++;
            $display("FAIL saturate got=%0d want=%0d", oBubbleCnt, CNT_MAX);
        end
        if (oStall !== 1'b1) cycle();
        checks++;
        if (oStall !== 1'b1 || oBubbleCnt !== CNT_MAX) begin
            failures++;
            $display("FAIL saturate_hold got stall=%b cnt=%0d want stall=1 cnt=%0d", oStall, oBubbleCnt, CNT_MAX);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (oStall !== 1'b0 || oBubbleCnt !== '0 || dutB !== '0) begin
            failures++;
            $display("FAIL async_reset got stall=%b cnt=%0d ex=%h want 0", oStall, oBubbleCnt, dutB);
        end
        modEx = '0;
        modCnt = 0;
        @(posedge clk); #1;
        rstN = 1'b1;
        inB = '0;
    endtask

    initial begin
        test_reset();
        test_load_visible();
        test_load_use();
        test_x0();
        test_flush();
        test_hold();
        test_back_to_back();
        test_saturate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
